aes_mix_columns_iter: RTL and testbench
=======================================

AES_MIX_COLUMNS_ITER -- requirements
Module: aes_mix_columns_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_state is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a new state.
REQ-005 SHALL have port in_state, input, 128 bits: AES state; column c occupies bits [127-32c : 96-32c]; the MSB byte of each column is row 0.
REQ-006 SHALL have port out_valid, output, 1 bit: out_state holds the result.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts out_state.
REQ-008 SHALL have port out_state, output, 128 bits: forward MixColumns of the accepted state, in the same layout as in_state.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement forward MixColumns per FIPS-197: each column is multiplied by the matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8), reduction polynomial 0x11B.
REQ-011 SHALL compute multiply-by-02 as xtime (shift left 1, XOR 0x1B if the shifted-out bit was 1), multiply-by-03 as xtime(x) XOR x, and SHALL use no lookup tables.
REQ-012 SHALL use an FSM with states IDLE, CALC and DONE.
REQ-013 IDLE: in_ready=1; in_valid=1 on a rising edge SHALL capture in_state into the working register, clear the 2-bit column counter to 0, and move to CALC.
REQ-014 CALC: each cycle SHALL replace column[counter] of the working register with its mixed value and increment the counter; the cycle that processes counter=3 SHALL move to DONE.
REQ-015 Latency SHALL be exactly 4 cycles: out_valid rises on the 4th rising edge after the accepting edge.
REQ-016 DONE: out_valid=1; out_state SHALL equal the working register and SHALL stay stable until out_ready=1; out_ready=1 on an edge SHALL return the FSM to IDLE.
REQ-017 in_ready SHALL be 0 in CALC and DONE; in_valid in those states SHALL be ignored, with no capture.
REQ-018 Throughput SHALL be one state per 6 cycles minimum (accept, 4×CALC, DONE handshake); the 2-bit counter wraps 3->0 only on leaving CALC.
REQ-019 out_ready asserted outside DONE SHALL have no effect.
REQ-020 out_state SHALL show the working register in all states; consumers use it only while out_valid=1.

Reset
REQ-021 When rst_n=0, the block SHALL immediately enter IDLE, regardless of the clock, with counter=0, working register=0, in_ready=1, out_valid=0, busy=0 and out_state=0.
REQ-022 A reset during CALC or DONE SHALL abort the operation with no output produced; the first accept after release SHALL behave per REQ-013.

Structure
REQ-023 The shared package aes_pkg SHALL hold the FSM state encoding, the constant AES_POLY = 8'h1B, and the xtime function.
REQ-024 Single-column arithmetic SHALL be in the combinational sub-module aes_mix_column (32-bit in, 32-bit out), with one instance muxed by the counter; it is the forward counterpart of the decryption column helper.

Verification
REQ-025 Column vectors via a full state with four equal columns SHALL give db135345->8e4da1bc, f20a225c->9fdc589d, 01010101->01010101, c6c6c6c6->c6c6c6c6, d4d4d4d5->d5d5d7d6, 2d26314c->4d7ebdf8.
REQ-026 FIPS-197 App. B round 1: in_state d4bf5d30e0b452aeb84111f11e2798e5 SHALL give out_state 046681e5e0cb199a48f8d37a2806264c, with out_valid exactly 4 cycles after acceptance.
REQ-027 Backpressure: out_ready held 0 for 10 cycles SHALL keep out_valid=1 with out_state stable and in_ready=0; a new in_valid offered meanwhile SHALL not be captured.
REQ-028 Back-to-back: in_valid held high with out_ready=1 SHALL accept a state every 6 cycles, with each result matching the model.
REQ-029 Reset mid-CALC: asserting rst_n=0 after 2 CALC cycles SHALL give out_valid=0 and in_ready=1 immediately, with no spurious output after release.
REQ-030 Random regression: 10,000 random states SHALL match a reference model's MixColumns, and an InvMixColumns model applied to each output SHALL return the input.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES MixColumns block.
// Holds the FSM state encoding, the AES reduction constant and the xtime helper
// (multiply by 02 in GF(2^8) with reduction polynomial 0x11B).
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mc_state_e;

  // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply by 02: shift left, fold the overflow bit back in via AES_POLY.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational forward MixColumns of a single 32-bit column.
// Forward counterpart of the decryption column helper.
// Ports:
//   col_in  - input column, bits [31:24] are row 0
//   col_out - mixed column, same layout
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] x0, x1, x2, x3;

  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];

  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  // Multiply-by-03 is written as xtime(b) ^ b.
  assign col_out[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
  assign col_out[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
  assign col_out[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
  assign col_out[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES forward MixColumns: one column per cycle through a single
// shared column mixer, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - input handshake; in_state captured in IDLE
//   in_state            - 128-bit state, column c at [127-32c : 96-32c]
//   out_valid, out_ready- output handshake; held in DONE until out_ready
//   out_state           - working register (result while out_valid=1)
//   busy                - high whenever the FSM is not idle
module aes_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  mc_state_e    state_q;
  logic [1:0]   cnt_q;
  logic [127:0] work_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [31:0]  col_sel;
  logic [31:0]  col_mixed;
  logic [127:0] work_upd;

  // Select the column addressed by the counter.
  always_comb begin
    col_sel = work_q[127:96];
    unique case (cnt_q)
      2'd0: col_sel = work_q[127:96];
      2'd1: col_sel = work_q[95:64];
      2'd2: col_sel = work_q[63:32];
      2'd3: col_sel = work_q[31:0];
      default: col_sel = work_q[127:96];
    endcase
  end

  aes_mix_column u_mix_column (
    .col_in  (col_sel),
    .col_out (col_mixed)
  );

  // Working register with the current column replaced by its mixed value.
  always_comb begin
    work_upd = work_q;
    unique case (cnt_q)
      2'd0: work_upd[127:96] = col_mixed;
      2'd1: work_upd[95:64]  = col_mixed;
      2'd2: work_upd[63:32]  = col_mixed;
      2'd3: work_upd[31:0]   = col_mixed;
      default: work_upd = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q     <= in_state;
            cnt_q      <= 2'd0;
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StCalc: begin
          work_q <= work_upd;
          // Natural 2-bit wrap brings the counter back to 0 as CALC ends.
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed and random checks of the iterative MixColumns block against a
// GF(2^8) multiply-based reference model and its inverse.
module tb_aes_mix_columns_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int errors = 0;
  int checks = 0;

  aes_mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] col_mul(input logic [31:0] c, input logic [7:0] m0,
                                          input logic [7:0] m1, input logic [7:0] m2,
                                          input logic [7:0] m3);
    logic [7:0] b [4];
    logic [7:0] k [4];
    logic [31:0] r;
    b[0] = c[31:24]; b[1] = c[23:16]; b[2] = c[15:8]; b[3] = c[7:0];
    k[0] = m0; k[1] = m1; k[2] = m2; k[3] = m3;
    for (int row = 0; row < 4; row++) begin
      logic [7:0] acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[(j - row + 4) % 4], b[j]);
      r[31 - 8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_mc(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      r[127 - 32*c -: 32] = col_mul(s[127 - 32*c -: 32], 8'h02, 8'h03, 8'h01, 8'h01);
    return r;
  endfunction

  function automatic logic [127:0] model_inv_mc(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      r[127 - 32*c -: 32] = col_mul(s[127 - 32*c -: 32], 8'h0E, 8'h0B, 8'h0D, 8'h09);
    return r;
  endfunction

  // One full transaction; caller checks results. Assumes block is idle.
  task automatic xfer(input logic [127:0] s, output logic [127:0] res, output int lat);
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_state !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_state=%h, want 1 0 0 0",
               in_ready, out_valid, busy, out_state);
    end
  endtask

  task automatic test_columns;
    logic [31:0] cin [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                             32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    logic [31:0] cexp [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                              32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
    logic [127:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      xfer({4{cin[i]}}, res, lat);
      checks++;
      if (res !== {4{cexp[i]}}) begin
        errors++;
        $display("FAIL column_%0d: got %h want %h", i, res, {4{cexp[i]}});
      end
    end
  endtask

  task automatic test_fips;
    logic [127:0] res;
    int lat;
    xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, res, lat);
    checks++;
    if (res !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
      errors++;
      $display("FAIL fips_result: got %h want 046681e5e0cb199a48f8d37a2806264c", res);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL fips_latency: got %0d want 4", lat);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_idle_after: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] s = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] exp_r = model_mc(s);
    int lat = 0;
    int bad = 0;
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
    end
    in_valid = 1'b1;
    in_state = 128'hffffffff_00000000_12345678_9abcdef0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== exp_r) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles, last out_valid=%b in_ready=%b out=%h want %h",
               bad, out_valid, in_ready, out_state, exp_r);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== exp_r) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b out=%h want 1 0 %h",
               in_ready, out_valid, out_state, exp_r);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vec [4] = '{128'h0123456789abcdeffedcba9876543210,
                              128'hdeadbeefcafebabe0badf00d12345678,
                              128'h55aa55aa33cc33cc0ff00ff0a5a5a5a5,
                              128'h80808080010101017f7f7f7ffefefefe};
    logic [127:0] expq [$];
    int accept_cyc [$];
    int idx = 0;
    int got = 0;
    logic [127:0] e;
    in_state = vec[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      logic acc = in_ready && in_valid && idx < 4;
      if (acc) begin
        expq.push_back(model_mc(vec[idx]));
        accept_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) in_state = vec[idx];
        else in_valid = 1'b0;
      end
      if (out_valid && expq.size() > 0) begin
        e = expq.pop_front();
        got++;
        checks++;
        if (out_state !== e) begin
          errors++;
          $display("FAIL b2b_result_%0d: got %h want %h", got, out_state, e);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 4", got);
    end
    for (int i = 1; i < accept_cyc.size(); i++) begin
      checks++;
      if (accept_cyc[i] - accept_cyc[i-1] != 6) begin
        errors++;
        $display("FAIL b2b_interval_%0d: got %0d want 6", i, accept_cyc[i] - accept_cyc[i-1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    int spurious = 0;
    logic [127:0] res;
    int lat;
    in_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_state !== '0) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b busy=%b out=%h want 0 1 0 0",
               out_valid, in_ready, busy, out_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_spurious: %0d cycles with activity want 0", spurious);
    end
    xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, res, lat);
    checks++;
    if (res !== 128'h046681e5e0cb199a48f8d37a2806264c || lat !== 4) begin
      errors++;
      $display("FAIL rst_recover: got %h lat %0d want 046681e5e0cb199a48f8d37a2806264c lat 4",
               res, lat);
    end
  endtask

  task automatic test_random;
    logic [127:0] s, res, e;
    int lat;
    for (int i = 0; i < 10000; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      xfer(s, res, lat);
      e = model_mc(s);
      checks++;
      if (res !== e || lat !== 4) begin
        errors++;
        $display("FAIL random_%0d: in %h got %h lat %0d want %h lat 4", i, s, res, lat, e);
      end
      checks++;
      if (model_inv_mc(res) !== s) begin
        errors++;
        $display("FAIL random_inv_%0d: inv(%h)=%h want %h", i, res, model_inv_mc(res), s);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_columns;
    test_fips;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_calc;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
